// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam int unsigned MEM_TIMEOUT_LIMIT = 255;

  // True when a writing stage targets a non-zero register equal to the source.
  function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand-forwarding select for one Execute-stage source operand.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdM,
  input  logic       regwriteM,
  input  logic [4:0] rdW,
  input  logic       regwriteW,
  output fwd_sel_t   sel
);

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    sel = FWD_RF;
    if (reg_match(regwriteM, rdM, rs)) begin
      sel = FWD_M;
    end else if (reg_match(regwriteW, rdW, rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch/memory-wait stalls, watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       loadE,
  input  logic       pcsrcE,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  output fwd_sel_t   forwardAE,
  output fwd_sel_t   forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles,
`endif
  output logic       mem_timeout
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT_LIMIT);

  hz_state_t  state_reg;
  logic [7:0] wait_cnt_reg;
  logic       mem_timeout_reg;
  logic       lw_stall;
  logic       mem_stall;

  logic [4:0] rs_e [2];
  fwd_sel_t   fwd_sel [2];

  assign rs_e[0] = rs1E;
  assign rs_e[1] = rs2E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_unit u_fwd (
        .rs        (rs_e[gi]),
        .rdM       (rdM),
        .regwriteM (regwriteM),
        .rdW       (rdW),
        .regwriteW (regwriteW),
        .sel       (fwd_sel[gi])
      );
    end
  endgenerate

  assign forwardAE = rst_n ? fwd_sel[0] : FWD_RF;
  assign forwardBE = rst_n ? fwd_sel[1] : FWD_RF;

  assign lw_stall  = loadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  // Mealy: the ack cycle already releases the pipeline, so no extra bubble.
  assign mem_stall = ((state_reg == RUN) && dmem_req && !dmem_ack) ||
                     ((state_reg == MEM_WAIT) && !dmem_ack);

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (!rst_n) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else begin
      stallF = lw_stall;
      stallD = lw_stall;
      flushD = pcsrcE;
      flushE = lw_stall || pcsrcE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
    end else begin
      // Flag rises one cycle after the counter saturates and is sticky until reset.
      if (wait_cnt_reg == WAIT_MAX) begin
        mem_timeout_reg <= 1'b1;
      end
      unique case (state_reg)
        RUN: begin
          if (dmem_req && !dmem_ack) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state_reg <= RUN;
          end else if (wait_cnt_reg != WAIT_MAX) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
      endcase
    end
  end

  assign mem_timeout = mem_timeout_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_cycles_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_reg <= 32'd0;
      flush_cycles_reg <= 32'd0;
    end else begin
      if (stallF) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (flushD) flush_cycles_reg <= flush_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_cycles = flush_cycles_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (optional counters under HAZARD_PERF_CNT_EN).
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteM, regwriteW, loadE, pcsrcE, dmem_req, dmem_ack;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1D        (rs1D),
    .rs2D        (rs2D),
    .rs1E        (rs1E),
    .rs2E        (rs2E),
    .rdE         (rdE),
    .rdM         (rdM),
    .rdW         (rdW),
    .regwriteM   (regwriteM),
    .regwriteW   (regwriteW),
    .loadE       (loadE),
    .pcsrcE      (pcsrcE),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE),
    .stallF      (stallF),
    .stallD      (stallD),
    .stallE      (stallE),
    .stallM      (stallM),
    .flushD      (flushD),
    .flushE      (flushE),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles),
`endif
    .mem_timeout (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Packs {stallF, stallD, stallE, stallM, flushD, flushE} for compact checks.
  function automatic logic [5:0] ctl();
    return {stallF, stallD, stallE, stallM, flushD, flushE};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regwriteM, regwriteW, loadE, pcsrcE, dmem_req, dmem_ack} = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    clr();
    rst_n = 1'b0;
    rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1;
    step();
    chk("rst_fwdA", 32'(forwardAE), 32'h0);
    chk("rst_ctl", 32'(ctl()), 32'b000011);
    chk("rst_timeout", 32'(mem_timeout), 32'h0);

    rst_n = 1'b1;
    clr();
    step();
    chk("idle_ctl", 32'(ctl()), 32'b000000);

    // Forwarding priority and the x0 exclusion
    rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1; rdW = 5'd5; regwriteW = 1'b1;
    #1 chk("fwdA_mem", 32'(forwardAE), 32'h2);
    chk("fwdB_none", 32'(forwardBE), 32'h0);
    rdM = 5'd0;
    #1 chk("fwdA_wb", 32'(forwardAE), 32'h1);
    clr();
    rs2E = 5'd9; rdW = 5'd9; regwriteW = 1'b1; rdM = 5'd9;
    #1 chk("fwdB_wb", 32'(forwardBE), 32'h1);
    regwriteM = 1'b1;
    #1 chk("fwdB_mem", 32'(forwardBE), 32'h2);
    rdW = 5'd0; regwriteM = 1'b0;
    #1 chk("fwdB_rf", 32'(forwardBE), 32'h0);

    // Load-use: one-cycle stall, then the load has moved on
    clr();
    loadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
    #1 chk("lw_stall", 32'(ctl()), 32'b110001);
    step();
    loadE = 1'b0; rdE = 5'd0;
    #1 chk("lw_released", 32'(ctl()), 32'b000000);
    loadE = 1'b1; rdE = 5'd0; rs2D = 5'd0;
    #1 chk("lw_rd0", 32'(ctl()), 32'b000000);

    // Branch combined with load-use
    clr();
    loadE = 1'b1; rdE = 5'd7; rs1D = 5'd7; pcsrcE = 1'b1;
    #1 chk("br_lw", 32'(ctl()), 32'b110011);
    loadE = 1'b0;
    #1 chk("br_only", 32'(ctl()), 32'b000011);
    step();

    // Memory wait: three stalled cycles, branch ignored, Mealy release on ack
    clr();
    dmem_req = 1'b1; pcsrcE = 1'b1;
    #1 chk("mw_c1", 32'(ctl()), 32'b111100);
    step();
    chk("mw_c2", 32'(ctl()), 32'b111100);
    step();
    chk("mw_c3", 32'(ctl()), 32'b111100);
    step();
    dmem_ack = 1'b1;
    #1 chk("mw_ack", 32'(ctl()), 32'b000011);
    step();
    clr();
    #1 chk("mw_run", 32'(ctl()), 32'b000000);

    // Watchdog: counter saturates after 256 edges, flag on edge 257
    dmem_req = 1'b1;
    repeat (256) step();
    chk("wd_pre", 32'(mem_timeout), 32'h0);
    step();
    chk("wd_set", 32'(mem_timeout), 32'h1);
    repeat (43) step();
    chk("wd_stall", 32'(ctl()), 32'b111100);
    dmem_ack = 1'b1;
    step();
    clr();
    step();
    chk("wd_sticky", 32'(mem_timeout), 32'h1);
    chk("wd_run", 32'(ctl()), 32'b000000);

    // Reset during a memory wait
    dmem_req = 1'b1;
    step();
    chk("rw_wait", 32'(ctl()), 32'b111100);
    rst_n = 1'b0;
    #1 chk("rw_inrst", 32'(ctl()), 32'b000011);
    step();
    rst_n = 1'b1;
    dmem_req = 1'b0;
    #1 chk("rw_run", 32'(ctl()), 32'b000000);
    chk("rw_timeout", 32'(mem_timeout), 32'h0);
    step();
    chk("rw_hold", 32'(ctl()), 32'b000000);

`ifdef HAZARD_PERF_CNT_EN
    chk("pc_stall0", stall_cycles, 32'd0);
    loadE = 1'b1; rdE = 5'd3; rs1D = 5'd3;
    repeat (10) step();
    clr();
    #1 chk("pc_stall10", stall_cycles, 32'd10);
    chk("pc_flush0", flush_cycles, 32'd0);
    pcsrcE = 1'b1;
    repeat (3) step();
    clr();
    #1 chk("pc_flush3", flush_cycles, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
